ksa_pipe_adder: RTL
===================

KSA_PIPE_ADDER -- requirements
Module: ksa_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal range 4..64.
REQ-002 SHALL derive constant LEVELS = clog2(WIDTH), the number of prefix levels.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous to clk and active-high.
REQ-005 SHALL have port in_valid  input  1  operand set offered.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand set this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in; ignored when sub=1.
REQ-010 SHALL have port sub  input  1  operation select: 0 = A+B+cin, 1 = A-B.
REQ-011 SHALL have port sat  input  1  operation select: 0 = modular result, 1 = unsigned saturating result.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port sum  output  WIDTH  result.
REQ-015 SHALL have port cout  output  1  raw carry out of the MSB, before saturation.
REQ-016 SHALL have port ovf  output  1  signed two's-complement overflow of the raw result.

Function
REQ-017 SHALL accept an operand set when in_valid && in_ready, and deliver it when out_valid && out_ready.
REQ-018 SHALL form B' = sub ? ~b : b and C0 = sub ? 1 : cin.
REQ-019 SHALL compute per-bit generate and propagate as g = a & B' and p = a ^ B'.
REQ-020 SHALL fold C0 in as a generate input at position -1.
REQ-021 SHALL resolve carries with a Kogge-Stone prefix tree: LEVELS levels, span 2^k at level k.
REQ-022 At each level, a position lacking a partner at distance 2^k SHALL pass its (G,P) through unchanged.
REQ-023 SHALL register the pipeline at three points: (1) after the g/p stage, (2) after every prefix level, (3) after the sum/saturate stage.
REQ-024 SHALL have latency L = LEVELS+2 cycles from the accepting edge to out_valid, with no stalls (L = 6 for WIDTH = 16).
REQ-025 SHALL compute the raw sum as sum_raw[i] = p[i] ^ carry[i], with carry[0] = C0.
REQ-026 SHALL set cout = carry[WIDTH].
REQ-027 SHALL set ovf = carry[WIDTH] ^ carry[WIDTH-1].
REQ-028 When sat = 1, sub = 0 and cout = 1, SHALL set sum to all ones.
REQ-029 When sat = 1, sub = 1 and cout = 0 (borrow), SHALL set sum to zero.
REQ-030 In all other cases, SHALL set sum to sum_raw.
REQ-031 SHALL carry sub and sat down the pipeline with each operand set.
REQ-032 SHALL use a global stall: in_ready = !out_valid || out_ready.
REQ-033 When stalled, all stages SHALL hold their state, and sum, cout and ovf SHALL remain stable while out_valid=1 && out_ready=0.
REQ-034 Bubbles SHALL propagate as per-stage valid=0; throughput SHALL be 1 result per cycle when out_ready is held high.
REQ-035 Simultaneous accept and deliver in one cycle SHALL be legal and lose no data.
REQ-036 in_valid with in_ready=0 SHALL cause no state change.
REQ-037 Operands SHALL be sampled only on an accepting edge.

Reset
REQ-038 When reset=1 at a clk edge, all stage valid bits SHALL clear and sum, cout and ovf SHALL go to 0.
REQ-039 After reset, out_valid SHALL be 0 and in_ready SHALL be 1 in the next cycle.
REQ-040 Reset mid-operation SHALL discard every in-flight operand set; no result from before reset SHALL ever appear.
REQ-041 reset SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-042 Package ksa_pkg SHALL hold the op-select type (ADD, SUB, ADD_SAT, SUB_SAT) and the clog2 helper function.
REQ-043 Sub-module ksa_prefix_cell SHALL implement the black cell G = Gh | Ph&Gl, P = Ph&Pl, with a grey-cell variant selected by a parameter.
REQ-044 The top level SHALL instantiate ksa_prefix_cell through generate loops.
REQ-045 The block SHALL contain no latches; all storage SHALL be flip-flops clocked by clk.

Verification
REQ-046 WIDTH=16, 0x00FF + 0x0001 (cin=0, sub=0, sat=0), out_ready=1 -> sum=0x0100, cout=0, ovf=0, out_valid exactly 6 cycles after accept.
REQ-047 WIDTH=16, 0xFFFF + 0x0001, sat=0 then sat=1 -> sum=0x0000, cout=1 for the first; sum=0xFFFF, cout=1 for the second.
REQ-048 WIDTH=16, 0x0003 - 0x0005, sat=0 then sat=1 -> sum=0xFFFE, cout=0 for the first; sum=0x0000 for the second.
REQ-049 WIDTH=16, 0x7FFF + 0x0001 -> sum=0x8000, ovf=1, cout=0.
REQ-050 Back-to-back stream of 20 random sets with out_ready toggling pseudo-randomly -> results in order, none lost or duplicated, outputs stable during stall.
REQ-051 Reset asserted with 3 sets in flight -> next cycle out_valid=0 and in_ready=1; none of the 3 results ever appear; WIDTH=6 and WIDTH=64 regressions also pass.

Source files
------------

// File: rtl/ksa_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
package ksa_pkg;

  typedef enum logic [1:0] {
    ADD     = 2'b00,
    SUB     = 2'b01,
    ADD_SAT = 2'b10,
    SUB_SAT = 2'b11
  } op_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 32'sd2) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  function automatic op_e op_decode(input logic sub, input logic sat);
    return op_e'({sat, sub});
  endfunction

endpackage

// File: rtl/ksa_prefix_cell.sv
// Kogge-Stone prefix cell: the black cell merges (G,P) pairs; the grey variant
// is used where the merged group already reaches bit 0, so only G is meaningful.
module ksa_prefix_cell #(
  parameter bit GREY = 1'b0
) (
  input  logic gh_i,
  input  logic ph_i,
  input  logic gl_i,
  input  logic pl_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = gh_i | (ph_i & gl_i);
  assign p_o = GREY ? 1'b0 : (ph_i & pl_i);

endmodule

// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with optional unsigned saturation.
// One register after g/p, one per prefix level, one after sum/saturate; global stall.
module ksa_pipe_adder
  import ksa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = clog2(WIDTH);

  logic                         en_s;
  logic [WIDTH-1:0]             bm_s;
  logic [WIDTH-1:0]             gen_s;
  logic [WIDTH-1:0]             prp_s;
  logic                         c0_s;
  logic                         g0_s;
  logic                         p0_s;
  logic [LEVELS-1:0][WIDTH-1:0] lvl_g_s;
  logic [LEVELS-1:0][WIDTH-1:0] lvl_p_s;
  logic                         unused_last_p_s;

  logic [LEVELS:0]              vld_q, vld_d;
  logic [LEVELS:0]              c0_q, c0_d;
  logic [LEVELS:0][WIDTH-1:0]   g_q, g_d;
  logic [LEVELS:0][WIDTH-1:0]   praw_q, praw_d;
  logic [LEVELS-1:0][WIDTH-1:0] p_q, p_d;
  op_e                          op_q [LEVELS+1];
  op_e                          op_d [LEVELS+1];

  logic [WIDTH:0]               carry_s;
  logic [WIDTH-1:0]             raw_s;
  logic [WIDTH-1:0]             sum_d, sum_q;
  logic                         cout_d, cout_q;
  logic                         ovf_d, ovf_q;
  logic                         out_valid_q;

  assign en_s     = !out_valid_q || out_ready;
  assign in_ready = en_s;

  assign bm_s  = sub ? ~b : b;
  assign c0_s  = sub ? 1'b1 : cin;
  assign gen_s = a & bm_s;
  assign prp_s = a ^ bm_s;

  // Carry-in is a generate at position -1, merged into bit 0 before the tree.
  ksa_prefix_cell #(.GREY(1'b1)) u_cin_cell (
    .gh_i (gen_s[0]),
    .ph_i (prp_s[0]),
    .gl_i (c0_s),
    .pl_i (1'b0),
    .g_o  (g0_s),
    .p_o  (p0_s)
  );

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (32'sd1 << k)) begin : g_cell
        ksa_prefix_cell #(.GREY(i < (32'sd2 << k))) u_cell (
          .gh_i (g_q[k][i]),
          .ph_i (p_q[k][i]),
          .gl_i (g_q[k][i - (32'sd1 << k)]),
          .pl_i (p_q[k][i - (32'sd1 << k)]),
          .g_o  (lvl_g_s[k][i]),
          .p_o  (lvl_p_s[k][i])
        );
      end else begin : g_pass
        assign lvl_g_s[k][i] = g_q[k][i];
        assign lvl_p_s[k][i] = p_q[k][i];
      end
    end
  end

  // Every group is complete after the last level, so its P is never consumed.
  assign unused_last_p_s = ^lvl_p_s[LEVELS-1];

  // Next-state for the g/p stage and every prefix-level stage.
  always_comb begin
    vld_d[0]  = in_valid;
    g_d[0]    = {gen_s[WIDTH-1:1], g0_s};
    p_d[0]    = {prp_s[WIDTH-1:1], p0_s};
    praw_d[0] = prp_s;
    c0_d[0]   = c0_s;
    op_d[0]   = op_decode(sub, sat);
    for (int k = 0; k < LEVELS; k++) begin
      vld_d[k+1]  = vld_q[k];
      g_d[k+1]    = lvl_g_s[k];
      praw_d[k+1] = praw_q[k];
      c0_d[k+1]   = c0_q[k];
      op_d[k+1]   = op_q[k];
    end
    for (int k = 0; k < LEVELS - 1; k++) begin
      p_d[k+1] = lvl_p_s[k];
    end
  end

  // Sum, flags and saturation from the resolved carries.
  always_comb begin
    carry_s = {g_q[LEVELS], c0_q[LEVELS]};
    raw_s   = praw_q[LEVELS] ^ carry_s[WIDTH-1:0];
    cout_d  = carry_s[WIDTH];
    ovf_d   = carry_s[WIDTH] ^ carry_s[WIDTH-1];
    sum_d   = raw_s;
    case (op_q[LEVELS])
      ADD_SAT: begin
        if (cout_d) sum_d = {WIDTH{1'b1}};
        else        sum_d = raw_s;
      end
      SUB_SAT: begin
        if (!cout_d) sum_d = {WIDTH{1'b0}};
        else         sum_d = raw_s;
      end
      default: sum_d = raw_s;
    endcase
  end

  // Pipeline and output registers; all stages advance together or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q       <= {(LEVELS+1){1'b0}};
      c0_q        <= {(LEVELS+1){1'b0}};
      g_q         <= '0;
      praw_q      <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= {WIDTH{1'b0}};
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      for (int s = 0; s <= LEVELS; s++) op_q[s] <= ADD;
    end else if (en_s) begin
      vld_q       <= vld_d;
      c0_q        <= c0_d;
      g_q         <= g_d;
      praw_q      <= praw_d;
      p_q         <= p_d;
      out_valid_q <= vld_q[LEVELS];
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      for (int s = 0; s <= LEVELS; s++) op_q[s] <= op_d[s];
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
